// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM and owner encodings plus
// the default memory latency and cache block geometry.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEF_MEM_LAT   = 4;
    localparam int DEF_BLK_WORDS = 8;
    localparam int WORD_IDX_W    = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache block fills, D-cache block fills and D-side write-through
// onto a single pipelined memory port; the D side has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int BLK_WORDS = DEF_BLK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [15:0]           i_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [15:0]           d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  i_fill_valid,
    output logic                  d_fill_valid,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [15:0]           fill_data,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_valid
);

    // The word index field in mem_addr is fixed at three bits, so blocks of
    // more than eight words cannot be addressed.
    if (MEM_LAT < 0 || BLK_WORDS < 2 || BLK_WORDS > 8) begin : g_param_check
        $error("mem_arbiter: unsupported MEM_LAT or BLK_WORDS");
    end

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLK_WORDS - 1);

    state_t                  state, state_nxt;
    owner_t                  owner, owner_nxt;
    logic [15:0]             addr_q, addr_nxt;
    logic [15:0]             wdata_q, wdata_nxt;
    logic [WORD_IDX_W-1:0]   issue_cnt, issue_nxt;
    logic [WORD_IDX_W-1:0]   ret_cnt, ret_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            issue_cnt <= issue_nxt;
            ret_cnt   <= ret_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        issue_nxt    = issue_cnt;
        ret_nxt      = ret_cnt;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_word    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;

        unique case (state)
            IDLE: begin
                issue_nxt = '0;
                ret_nxt   = '0;
                if (d_req) begin
                    owner_nxt = OWN_D;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                    state_nxt = d_we ? WRITE : ISSUE;
                end else if (i_req) begin
                    owner_nxt = OWN_I;
                    addr_nxt  = i_addr;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_addr  = {addr_q[15:4], issue_cnt, 1'b0};
                issue_nxt = issue_cnt + 1'b1;
                if (issue_cnt == LAST_WORD) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Returns are accepted while issues are still going out, so the last
        // return may close the operation from either ISSUE or WAIT.
        if ((state == ISSUE || state == WAIT) && mem_valid) begin
            fill_word = ret_cnt;
            ret_nxt   = ret_cnt + 1'b1;
            if (owner == OWN_D) begin
                d_fill_valid = 1'b1;
            end else begin
                i_fill_valid = 1'b1;
            end
            if (ret_cnt == LAST_WORD) begin
                state_nxt = IDLE;
                if (owner == OWN_D) begin
                    d_done = 1'b1;
                end else begin
                    i_done = 1'b1;
                end
            end
        end
    end

    assign fill_data = rst ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives a latency-programmable memory model
// and checks each cycle of fills, writes, arbitration and reset behaviour.
module tb_mem_arbiter;

    localparam int BLK_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;
    logic        inject;
    logic        pv [0:15];
    logic [15:0] pa [0:15];

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEM_LAT   (4),
        .BLK_WORDS (BLK_WORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .i_fill_valid (i_fill_valid),
        .d_fill_valid (d_fill_valid),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .i_done       (i_done),
        .d_done       (d_done),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid)
    );

    function automatic logic [15:0] rdataOf(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %04h, expected %04h", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, " mem_en"}, mem_en, 1'b0);
        checkBit({tag, " i_fill_valid"}, i_fill_valid, 1'b0);
        checkBit({tag, " d_fill_valid"}, d_fill_valid, 1'b0);
        checkBit({tag, " i_done"}, i_done, 1'b0);
        checkBit({tag, " d_done"}, d_done, 1'b0);
    endtask

    task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                 input logic dw, input logic [15:0] da, input logic [15:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic setLatency(input int l);
        lat = l;
        for (int j = 0; j < 16; j++) begin
            pv[j] = 1'b0;
            pa[j] = '0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the
    // memory model's response for the new cycle already applied.
    task automatic nextCycle();
        logic        issued;
        logic [15:0] a;
        issued = mem_en && !mem_wr;
        a      = mem_addr;
        @(posedge clk);
        #1;
        for (int j = 15; j > 0; j--) begin
            pv[j] = pv[j-1];
            pa[j] = pa[j-1];
        end
        pv[0] = issued;
        pa[0] = a;
        mem_valid = pv[lat-1] | inject;
        mem_rdata = pv[lat-1] ? rdataOf(pa[lat-1]) : (inject ? 16'hDEAD : 16'hC0DE);
        @(negedge clk);
    endtask

    // Entered in the grant cycle; leaves in the done cycle with the owner's
    // request dropped.
    task automatic runFill(input string tag, input logic is_d, input logic [15:0] base,
                           input int drop_at);
        int   ret;
        int   last;
        logic own_v, oth_v, own_d, oth_d;
        last = BLK_WORDS + lat;
        for (int k = 1; k <= last; k++) begin
            nextCycle();
            ret   = k - 1 - lat;
            own_v = is_d ? d_fill_valid : i_fill_valid;
            oth_v = is_d ? i_fill_valid : d_fill_valid;
            own_d = is_d ? d_done : i_done;
            oth_d = is_d ? i_done : d_done;
            checkBit($sformatf("%s mem_en k%0d", tag, k), mem_en, k <= BLK_WORDS);
            checkBit($sformatf("%s mem_wr k%0d", tag, k), mem_wr, 1'b0);
            if (k <= BLK_WORDS) begin
                checkOutput($sformatf("%s mem_addr k%0d", tag, k), mem_addr, base + 16'(2 * (k - 1)));
            end
            checkBit($sformatf("%s own fill_valid k%0d", tag, k), own_v, ret >= 0);
            checkBit($sformatf("%s other fill_valid k%0d", tag, k), oth_v, 1'b0);
            if (ret >= 0) begin
                checkOutput($sformatf("%s fill_word k%0d", tag, k), 16'(fill_word), 16'(ret));
                checkOutput($sformatf("%s fill_data k%0d", tag, k), fill_data,
                            rdataOf(base + 16'(2 * ret)));
            end
            checkBit($sformatf("%s own done k%0d", tag, k), own_d, k == last);
            checkBit($sformatf("%s other done k%0d", tag, k), oth_d, 1'b0);
            if (k == 1) begin
                if (is_d) d_addr = 16'hFFFF;
                else      i_addr = 16'hFFFF;
            end
            if (k == drop_at || k == last) begin
                if (is_d) d_req = 1'b0;
                else      i_req = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        inject    = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 16'hC0DE;
        setLatency(4);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

        @(negedge clk);
        $display("[TB] reset state");
        checkQuiet("reset");
        checkBit("reset mem_wr", mem_wr, 1'b0);
        checkOutput("reset mem_addr", mem_addr, 16'h0000);
        checkOutput("reset mem_wdata", mem_wdata, 16'h0000);
        checkOutput("reset fill_word", 16'(fill_word), 16'h0000);
        checkOutput("reset fill_data", fill_data, 16'h0000);
        rst = 1'b0;
        nextCycle();
        checkQuiet("idle");

        $display("[TB] single I fill from 0x1234");
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000);
        runFill("S1", 1'b0, 16'h1230, 0);
        nextCycle();
        checkQuiet("S1 after");

        $display("[TB] stray mem_valid in IDLE");
        inject = 1'b1;
        nextCycle();
        checkQuiet("idle stray");
        inject = 1'b0;

        $display("[TB] simultaneous D fill and I fill");
        applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h8000, 16'h0000);
        runFill("S2-D", 1'b1, 16'h8000, 0);
        nextCycle();
        checkQuiet("S2 gap");
        runFill("S2-I", 1'b0, 16'h0040, 0);
        nextCycle();
        checkQuiet("S2 after");

        $display("[TB] D write-through");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A2, 16'hBEEF);
        inject = 1'b1;
        nextCycle();
        d_addr  = 16'h5555;
        d_wdata = 16'h1111;
        #1;
        checkBit("S3 mem_en", mem_en, 1'b1);
        checkBit("S3 mem_wr", mem_wr, 1'b1);
        checkOutput("S3 mem_addr", mem_addr, 16'h00A2);
        checkOutput("S3 mem_wdata", mem_wdata, 16'hBEEF);
        checkBit("S3 d_done", d_done, 1'b1);
        checkBit("S3 i_done", i_done, 1'b0);
        checkBit("S3 d_fill_valid", d_fill_valid, 1'b0);
        checkBit("S3 i_fill_valid", i_fill_valid, 1'b0);
        d_req  = 1'b0;
        d_we   = 1'b0;
        inject = 1'b0;
        nextCycle();
        checkQuiet("S3 after");
        checkBit("S3 after mem_wr", mem_wr, 1'b0);

        $display("[TB] reset during I fill");
        applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checkBit($sformatf("S4 mem_en k%0d", k), mem_en, 1'b1);
            checkOutput($sformatf("S4 mem_addr k%0d", k), mem_addr, 16'h2000 + 16'(2 * (k - 1)));
        end
        rst   = 1'b1;
        i_req = 1'b0;
        #1;
        checkQuiet("S4 in reset");
        checkOutput("S4 in reset mem_addr", mem_addr, 16'h0000);
        checkOutput("S4 in reset fill_data", fill_data, 16'h0000);
        nextCycle();
        checkQuiet("S4 reset held");
        rst = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            nextCycle();
            checkQuiet($sformatf("S4 stale k%0d", k));
        end

        $display("[TB] I request dropped after grant");
        applyStimulus(1'b1, 16'h3456, 1'b0, 1'b0, 16'h0000, 16'h0000);
        runFill("S5", 1'b0, 16'h3450, 2);
        nextCycle();
        checkQuiet("S5 after");

        $display("[TB] memory latency 1");
        setLatency(1);
        applyStimulus(1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000, 16'h0000);
        runFill("S6-I", 1'b0, 16'hABC0, 0);
        nextCycle();
        checkQuiet("S6 gap");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h7FFE, 16'h0000);
        runFill("S6-D", 1'b1, 16'h7FF0, 0);
        nextCycle();
        checkQuiet("S6 after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4: cycles from a sampled mem_en to the matching mem_valid.
REQ-002 SHALL have parameter BLK_WORDS, default 8: 16-bit words per cache block.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-high, port rst.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port i_req, input, 1 bit: I-cache miss fill request, held until i_done.
REQ-007 SHALL have port i_addr, input, 16 bits: I-side miss byte address.
REQ-008 SHALL have port d_req, input, 1 bit: D-side request, held until d_done.
REQ-009 SHALL have port d_we, input, 1 bit: 1 = single-word write-through, 0 = block fill.
REQ-010 SHALL have port d_addr, input, 16 bits: D-side byte address.
REQ-011 SHALL have port d_wdata, input, 16 bits: D-side write data.
REQ-012 SHALL have ports i_fill_valid and d_fill_valid, output, 1 bit each: returned fill word valid for that side.
REQ-013 SHALL have port fill_word, output, 3 bits: word index of the returned word.
REQ-014 SHALL have port fill_data, output, 16 bits: returned word, equal to mem_rdata.
REQ-015 SHALL have ports i_done and d_done, output, 1 bit each: one-cycle completion pulse.
REQ-016 SHALL have ports mem_en and mem_wr, output, 1 bit each: memory access strobe and write select.
REQ-017 SHALL have port mem_addr, output, 16 bits: memory byte address.
REQ-018 SHALL have port mem_wdata, output, 16 bits: memory write data.
REQ-019 SHALL have port mem_rdata, input, 16 bits: memory read data.
REQ-020 SHALL have port mem_valid, input, 1 bit: mem_rdata valid.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, WRITE.
REQ-022 IDLE transitions: d_req&d_we -> WRITE; d_req&~d_we -> ISSUE (owner D); else i_req -> ISSUE (owner I); else stay in IDLE.
REQ-023 D side SHALL win when d_req and i_req are high in the same cycle; no preemption once an operation has started.
REQ-024 SHALL latch owner and block base, addr[15:4], on leaving IDLE; later changes to the address inputs are ignored.
REQ-025 ISSUE SHALL run BLK_WORDS consecutive cycles: mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0}, issue_cnt 0..7, then go to WAIT.
REQ-026 Every cycle in ISSUE/WAIT with mem_valid=1 SHALL assert the owner's fill_valid, set fill_word=ret_cnt, and increment ret_cnt (3-bit, wraps 7->0).
REQ-027 The 8th return SHALL pulse the owner's done in the same cycle and move the FSM to IDLE, even if it arrives while still in ISSUE.
REQ-028 Fill latency SHALL be: grant cycle T, issues T+1..T+8, returns T+1+MEM_LAT..T+8+MEM_LAT, done at T+8+MEM_LAT.
REQ-029 WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata; d_done pulses in that cycle; next state IDLE.
REQ-030 Back-to-back: a request pending at done SHALL be granted in the first IDLE cycle after done (one-cycle gap).
REQ-031 mem_valid received in IDLE or WRITE SHALL be ignored; no fill_valid is produced.
REQ-032 Deasserting a request mid-operation SHALL NOT abort the operation; done still pulses.
REQ-033 mem_en SHALL be 0 in IDLE and WAIT; fill_valid and done SHALL go only to the latched owner.

Reset
REQ-034 rst SHALL force IDLE, clear counters and owner, and drive all outputs to 0 asynchronously.
REQ-035 rst mid-operation SHALL abandon the operation with no done pulse; returns arriving after reset are ignored per REQ-031.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the owner encoding (OWN_I, OWN_D), and the defaults MEM_LAT=4 and BLK_WORDS=8.
REQ-037 The block SHALL be a single module with no sub-module; counters and FSM are inline.

Verification
REQ-038 Scenario: i_req, i_addr=0x1234 -> mem_addr 0x1230..0x123E over 8 cycles, 8 i_fill_valid with fill_word 0..7, i_done at T+12.
REQ-039 Scenario: d_req (d_we=0, d_addr=0x8000) and i_req (i_addr=0x0040) rise together -> D fill completes first, then I fill granted exactly one cycle after d_done.
REQ-040 Scenario: d_req, d_we=1, d_addr=0x00A2, d_wdata=0xBEEF -> one cycle of mem_en=1, mem_wr=1, mem_addr=0x00A2, mem_wdata=0xBEEF, with d_done in that same cycle.
REQ-041 Scenario: rst asserted at the 5th issue cycle -> outputs 0 immediately, no i_done, and the following stale mem_valid pulses produce no fill_valid.
REQ-042 Scenario: i_req dropped 2 cycles after grant -> all 8 fills still delivered and i_done still pulses.
REQ-043 Scenario: MEM_LAT=1 -> 8th return lands in WAIT at T+9, done and IDLE occur correctly, and ret_cnt wraps to 0.
